char_stream_cursor: RTL and testbench

CHAR_STREAM_CURSOR -- requirements
Module: char_stream_cursor

---
 rtl/char_stream_cursor_if.sv | 32 +++
 rtl/char_stream_cursor.sv | 113 +++++++++++
 tb/tb_char_stream_cursor.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/char_stream_cursor_if.sv
// Handshake and control bundle between a byte producer, the cursor and a backtracking char parser.
// The slave modport is the cursor side; the master modport is the producer/parser side.
interface char_stream_cursor_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_eof;
  logic          mark;
  logic          rewind;
  logic          commit;
  logic          mark_valid;
  logic          rewind_err;
  logic [LW-1:0] level;

  modport master (
    output in_valid, in_data, in_last, out_ready, mark, rewind, commit,
    input  in_ready, out_valid, out_data, out_eof, mark_valid, rewind_err, level
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready, mark, rewind, commit,
    output in_ready, out_valid, out_data, out_eof, mark_valid, rewind_err, level
  );
endinterface

// File: rtl/char_stream_cursor.sv
// Byte buffer with a read cursor that can be checkpointed and rewound; written bytes are visible
// one cycle later, and the producer stalls when bytes from the checkpoint to wr fill the buffer.
module char_stream_cursor #(
  parameter int DEPTH = 16
) (
  input logic                clk,
  input logic                rst_n,
  char_stream_cursor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_mk;
  logic          r_closed;
  logic          r_mark_valid;
  logic          r_rewind_err;

  logic [PW-1:0] w_base;
  logic [PW-1:0] w_level;
  logic          w_in_ready;
  logic          w_wr_fire;
  logic          w_out_valid;
  logic          w_rd_fire;
  logic          w_rewind_ok;
  logic          w_rewind_bad;

  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_rd_nxt;
  logic [PW-1:0] w_mk_nxt;
  logic          w_closed_nxt;
  logic          w_mark_valid_nxt;

  // Occupancy is measured from the checkpoint while one is held, so marked bytes are protected.
  assign w_base      = r_mark_valid ? r_mk : r_rd;
  assign w_level     = r_wr - w_base;
  assign w_in_ready  = !r_closed && (w_level < FULL);
  assign w_wr_fire   = bus.in_valid && w_in_ready;
  assign w_out_valid = (r_rd != r_wr);
  assign w_rd_fire   = w_out_valid && bus.out_ready && !bus.rewind;

  assign w_rewind_ok  = bus.rewind && r_mark_valid;
  assign w_rewind_bad = bus.rewind && !r_mark_valid;

  always_comb begin
    w_wr_nxt     = r_wr;
    w_closed_nxt = r_closed;
    if (w_wr_fire) begin
      w_wr_nxt = r_wr + ONE;
      if (bus.in_last) begin
        w_closed_nxt = 1'b1;
      end
    end
  end

  // A successful rewind swallows the same-cycle read, mark and commit.
  always_comb begin
    w_rd_nxt         = r_rd;
    w_mk_nxt         = r_mk;
    w_mark_valid_nxt = r_mark_valid;
    if (w_rewind_ok) begin
      w_rd_nxt         = r_mk;
      w_mark_valid_nxt = 1'b0;
    end else begin
      if (w_rd_fire) begin
        w_rd_nxt = r_rd + ONE;
      end
      if (bus.mark) begin
        w_mk_nxt         = r_rd;
        w_mark_valid_nxt = 1'b1;
      end else if (bus.commit) begin
        w_mark_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr         <= '0;
      r_rd         <= '0;
      r_mk         <= '0;
      r_closed     <= 1'b0;
      r_mark_valid <= 1'b0;
      r_rewind_err <= 1'b0;
    end else begin
      r_wr         <= w_wr_nxt;
      r_rd         <= w_rd_nxt;
      r_mk         <= w_mk_nxt;
      r_closed     <= w_closed_nxt;
      r_mark_valid <= w_mark_valid_nxt;
      r_rewind_err <= w_rewind_bad;
    end
  end

  // Storage needs no reset: out_data is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr[AW-1:0]] <= bus.in_data;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = r_mem[r_rd[AW-1:0]];
  assign bus.out_eof    = r_closed && (r_rd == r_wr);
  assign bus.mark_valid = r_mark_valid;
  assign bus.rewind_err = r_rewind_err;
  assign bus.level      = w_level;
endmodule

// File: tb/tb_char_stream_cursor.sv
// Randomized and directed bench for char_stream_cursor against an unbounded-position stream model.
module tb_char_stream_cursor;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: absolute byte positions that never wrap, plus the full byte history.
  byte unsigned m_q[$];
  int           m_wr, m_rd, m_mk;
  bit           m_mv, m_closed, m_err;

  char_stream_cursor_if #(.DEPTH(DEPTH)) bus ();

  char_stream_cursor #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_all();
    int  base, lvl;
    bit  ovld;
    base = m_mv ? m_mk : m_rd;
    lvl  = m_wr - base;
    ovld = (m_rd != m_wr);
    check_eq("in_ready",   32'(bus.in_ready),   32'(!m_closed && lvl < DEPTH));
    check_eq("out_valid",  32'(bus.out_valid),  32'(ovld));
    if (ovld) check_eq("out_data", 32'(bus.out_data), 32'(m_q[m_rd]));
    check_eq("out_eof",    32'(bus.out_eof),    32'(m_closed && !ovld));
    check_eq("level",      32'(bus.level),      32'(lvl));
    check_eq("mark_valid", 32'(bus.mark_valid), 32'(m_mv));
    check_eq("rewind_err", 32'(bus.rewind_err), 32'(m_err));
  endtask

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    bus.mark      = 1'b0;
    bus.rewind    = 1'b0;
    bus.commit    = 1'b0;
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model, check at the next falling edge.
  task automatic step(input bit iv, input logic [7:0] d, input bit il, input bit ordy,
                      input bit mk, input bit rw, input bit cm);
    int base, lvl, old_rd;
    bit irdy, ovld, rdf;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_last   = il;
    bus.out_ready = ordy;
    bus.mark      = mk;
    bus.rewind    = rw;
    bus.commit    = cm;
    base   = m_mv ? m_mk : m_rd;
    lvl    = m_wr - base;
    irdy   = !m_closed && lvl < DEPTH;
    ovld   = (m_rd != m_wr);
    rdf    = ovld && ordy && !rw;
    old_rd = m_rd;
    m_err  = rw && !m_mv;
    if (rw && m_mv) begin
      m_rd = m_mk;
      m_mv = 1'b0;
    end else begin
      if (rdf) m_rd++;
      if (mk) begin
        m_mk = old_rd;
        m_mv = 1'b1;
      end else if (cm) begin
        m_mv = 1'b0;
      end
    end
    if (iv && irdy) begin
      m_q.push_back(d);
      m_wr++;
      if (il) m_closed = 1'b1;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic wr_byte(input logic [7:0] d, input bit last);
    step(1'b1, d, last, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd_byte();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset is asserted mid-cycle, away from any clock edge, and checked before the next rising edge.
  task automatic apply_reset();
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    m_q.delete();
    m_wr = 0; m_rd = 0; m_mk = 0;
    m_mv = 1'b0; m_closed = 1'b0; m_err = 1'b0;
    check_eq("rst_in_ready",   32'(bus.in_ready),   32'd1);
    check_eq("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check_eq("rst_out_eof",    32'(bus.out_eof),    32'd0);
    check_eq("rst_level",      32'(bus.level),      32'd0);
    check_eq("rst_mark_valid", 32'(bus.mark_valid), 32'd0);
    check_eq("rst_rewind_err", 32'(bus.rewind_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b1;
    drive_idle();
    @(negedge clk);
    apply_reset();

    // Simple string, read back in order, then end of string with the producer closed.
    wr_byte(8'h61, 1'b0);
    check_eq("first_byte_visible", 32'(bus.out_data), 32'h61);
    wr_byte(8'h62, 1'b0);
    wr_byte(8'h63, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq("str_order", 32'(bus.out_data), 32'h61 + 32'(i));
      rd_byte();
    end
    check_eq("str_eof",      32'(bus.out_eof),  32'd1);
    check_eq("str_in_ready", 32'(bus.in_ready), 32'd0);

    // Checkpoint, consume two bytes, rewind back to the checkpoint.
    apply_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wr_byte(8'h61, 1'b0);
    wr_byte(8'h62, 1'b0);
    wr_byte(8'h63, 1'b0);
    rd_byte();
    rd_byte();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("rewind_data",  32'(bus.out_data),   32'h61);
    check_eq("rewind_mv",    32'(bus.mark_valid), 32'd0);
    check_eq("rewind_level", 32'(bus.level),      32'd3);

    // Full buffer behind a checkpoint keeps stalling even once everything is read.
    apply_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) wr_byte(8'(8'h80 + i), 1'b0);
    check_eq("full_level", 32'(bus.level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("full_stall", 32'(bus.in_ready), 32'd0);
      step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check_eq("full_empty_rd",    32'(bus.out_valid), 32'd0);
    check_eq("full_still_stall", 32'(bus.in_ready),  32'd0);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("commit_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("commit_level",    32'(bus.level),    32'd0);

    // Rewind without a checkpoint, then rewind colliding with mark/read/commit.
    apply_reset();
    wr_byte(8'h11, 1'b0);
    wr_byte(8'h22, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("err_pulse_hi", 32'(bus.rewind_err), 32'd1);
    check_eq("err_rd_same",  32'(bus.out_data),   32'h11);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("err_pulse_lo", 32'(bus.rewind_err), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rd_byte();
    check_eq("pre_collide_data", 32'(bus.out_data), 32'h22);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("collide_mv",   32'(bus.mark_valid), 32'd0);
    check_eq("collide_data", 32'(bus.out_data),   32'h11);
    check_eq("collide_lvl",  32'(bus.level),      32'd2);

    // Rewind after end of string reopens the cursor.
    apply_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wr_byte(8'h31, 1'b0);
    wr_byte(8'h32, 1'b1);
    rd_byte();
    rd_byte();
    check_eq("eof_before_rewind", 32'(bus.out_eof), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("eof_after_rewind", 32'(bus.out_eof),  32'd0);
    check_eq("eof_rewind_data",  32'(bus.out_data), 32'h31);

    // Asynchronous reset with bytes buffered and a checkpoint held.
    apply_reset();
    for (int i = 0; i < 5; i++) wr_byte(8'(8'h40 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("pre_rst_level", 32'(bus.level),      32'd5);
    check_eq("pre_rst_mv",    32'(bus.mark_valid), 32'd1);
    apply_reset();

    // Random traffic with stalls, checkpoints and wrapping pointers.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), 1'b0, $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0);
      check_eq("level_bound", 32'(bus.level <= DEPTH), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
